// File: rtl/sram_controller_wakeup_sequencer_if.sv
// Bank request/status bundle between the power-management master and the
// multi-bank SRAM wakeup sequencer.
interface sram_controller_wakeup_sequencer_if #(
    parameter int NUM_BANKS = 4,
    parameter int CNT_W     = 4
);
    logic [NUM_BANKS-1:0] wake_req;     // per-bank level request
    logic [CNT_W-1:0]     wake_cycles;  // programmed wakeup length
    logic [NUM_BANKS-1:0] power_en;     // bank power-switch enables
    logic [NUM_BANKS-1:0] bank_ready;   // bank usable
    logic                 busy;         // some bank is waking
    logic [CNT_W-1:0]     wake_count;   // debug view of the shared counter

    modport master (
        output wake_req, wake_cycles,
        input  power_en, bank_ready, busy, wake_count
    );

    modport slave (
        input  wake_req, wake_cycles,
        output power_en, bank_ready, busy, wake_count
    );
endinterface

// File: rtl/sram_controller_wakeup_sequencer.sv
// Multi-bank SRAM wakeup sequencer. Banks are powered up one at a time
// (round-robin arbitration) to bound inrush current; each wakeup runs for
// max(wake_cycles, MIN_WAKE_CYCLES) cycles before the bank is declared ready.
module sram_controller_wakeup_sequencer #(
    parameter int NUM_BANKS       = 4,
    parameter int CNT_W           = 4,
    parameter int MIN_WAKE_CYCLES = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    sram_controller_wakeup_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        BANK_OFF     = 2'd0,
        BANK_QUEUED  = 2'd1,
        BANK_WAKING  = 2'd2,
        BANK_READY   = 2'd3
    } bank_state_e;

    localparam int                IDX_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_WAKE_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BANKS - 1);

    bank_state_e          state_q [NUM_BANKS];
    bank_state_e          state_d [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     target_q, target_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;

    logic [NUM_BANKS-1:0] waking_mask;
    logic [NUM_BANKS-1:0] ready_mask;
    logic                 any_waking;
    logic                 abort_waking;
    logic                 wake_done;
    logic [CNT_W-1:0]     wake_target;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand_idx;

    // Decode the per-bank states into waking/ready masks.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        waking_mask = '0;
        ready_mask  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            waking_mask[i] = (state_q[i] == BANK_WAKING);
            ready_mask[i]  = (state_q[i] == BANK_READY);
        end
    end

    assign any_waking   = |waking_mask;
    // Only one bank can be waking, so any waking bank with its request low is an abort.
    assign abort_waking = |(waking_mask & ~bus.wake_req);
    assign wake_done    = any_waking && (cnt_q == (target_q - CNT_W'(1)));
    assign wake_target  = (bus.wake_cycles < MIN_CNT) ? MIN_CNT : bus.wake_cycles;

    // Round-robin search from last_grant+1; grants only when the slot is free.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant_q;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_BANKS; k++) begin
            cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_BANKS);
            if (!grant_valid && !any_waking && bus.wake_req[cand_idx] &&
                (state_q[cand_idx] == BANK_OFF || state_q[cand_idx] == BANK_QUEUED)) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Next-state logic for bank states, shared counter, target and pointer.
    always_comb begin
        cnt_d        = cnt_q;
        target_d     = target_q;
        last_grant_d = last_grant_q;
        for (int i = 0; i < NUM_BANKS; i++) begin
            state_d[i] = state_q[i];
            if (!bus.wake_req[i]) begin
                state_d[i] = BANK_OFF;
            end else begin
                unique case (state_q[i])
                    BANK_OFF:    state_d[i] = (grant_valid && grant_idx == IDX_W'(i)) ?
                                              BANK_WAKING : BANK_QUEUED;
                    BANK_QUEUED: if (grant_valid && grant_idx == IDX_W'(i)) state_d[i] = BANK_WAKING;
                    BANK_WAKING: if (wake_done) state_d[i] = BANK_READY;
                    BANK_READY:  state_d[i] = BANK_READY;
                    default:     state_d[i] = BANK_OFF;
                endcase
            end
        end

        if (grant_valid) begin
            cnt_d        = '0;
            target_d     = wake_target;
            last_grant_d = grant_idx;
        end else if (any_waking) begin
            cnt_d = (abort_waking || wake_done) ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset; reset wins over every event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= BANK_OFF;
            cnt_q        <= '0;
            target_q     <= '0;
            last_grant_q <= LAST_IDX;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= state_d[i];
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.power_en   = waking_mask | ready_mask;
    assign bus.bank_ready = ready_mask;
    assign bus.busy       = any_waking;
    assign bus.wake_count = cnt_q;

endmodule

// File: tb/tb_sram_controller_wakeup_sequencer.sv
// Self-checking bench for the multi-bank wakeup sequencer. Expected outputs
// are derived from the documented timing and queued per edge; they are
// popped and compared when the DUT reaches that edge.
module tb_sram_controller_wakeup_sequencer;

    localparam int NB   = 4;
    localparam int CW   = 4;
    localparam int MINW = 4;

    localparam int SEL_PWR  = 0;
    localparam int SEL_RDY  = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_CNT  = 3;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sram_controller_wakeup_sequencer_if #(.NUM_BANKS(NB), .CNT_W(CW)) bus ();

    sram_controller_wakeup_sequencer #(
        .NUM_BANKS       (NB),
        .CNT_W           (CW),
        .MIN_WAKE_CYCLES (MINW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    sb_t sb[$];
    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_err  = 0;

    task automatic expect_all(input int c, input logic [3:0] pwr, input logic [3:0] rdy,
                              input logic bsy, input logic [3:0] cnt, input string nm);
        sb.push_back('{c, SEL_PWR,  32'(pwr), {nm, ".power_en"}});
        sb.push_back('{c, SEL_RDY,  32'(rdy), {nm, ".bank_ready"}});
        sb.push_back('{c, SEL_BUSY, 32'(bsy), {nm, ".busy"}});
        sb.push_back('{c, SEL_CNT,  32'(cnt), {nm, ".wake_count"}});
    endtask

    task automatic expect_one(input int c, input int sel, input logic [31:0] v, input string nm);
        sb.push_back('{c, sel, v, nm});
    endtask

    // One rising edge, then settle before sampling.
    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit pop_due(output sb_t e);
        e = '{0, 0, '0, ""};
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == cyc) begin
                e = sb[i];
                sb.delete(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_PWR:  return 32'(bus.power_en);
            SEL_RDY:  return 32'(bus.bank_ready);
            SEL_BUSY: return 32'(bus.busy);
            default:  return 32'(bus.wake_count);
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus.wake_req = '0;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        reset = 1'b1;
        bus.wake_req    = '0;
        bus.wake_cycles = '0;
        expect_all(cyc + 1, 4'b0000, 4'b0000, 1'b0, 4'd0, "reset");
        expect_all(cyc + 2, 4'b0000, 4'b0000, 1'b0, 4'd0, "reset_idle");
        for (int k = 0; k < 2; k++) begin
            if (k == 1) reset = 1'b0;
            advance();
            while (pop_due(e)) begin
                n_cmp++;
                if (observe(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc%0d: got %0h expected %0h", e.name, cyc, observe(e.sel), e.exp);
                end
            end
        end
    endtask

    // Single bank, wake_cycles=6, then release and immediate re-request.
    task automatic test_basic();
        sb_t e;
        int  base = cyc + 1;
        for (int j = 0; j < 6; j++) expect_all(base + j, 4'b0001, 4'b0000, 1'b1, 4'(j), "basic_wake");
        expect_all(base + 6, 4'b0001, 4'b0001, 1'b0, 4'd0, "basic_ready");
        expect_all(base + 7, 4'b0000, 4'b0000, 1'b0, 4'd0, "basic_release");
        for (int j = 0; j < 6; j++) expect_all(base + 8 + j, 4'b0001, 4'b0000, 1'b1, 4'(j), "rereq_wake");
        expect_all(base + 14, 4'b0001, 4'b0001, 1'b0, 4'd0, "rereq_ready");
        expect_all(base + 15, 4'b0000, 4'b0000, 1'b0, 4'd0, "rereq_release");
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:  begin bus.wake_req = 4'b0001; bus.wake_cycles = 4'd6; end
                7:  bus.wake_req = 4'b0000;
                8:  bus.wake_req = 4'b0001;
                15: bus.wake_req = 4'b0000;
                default: ;
            endcase
            advance();
            while (pop_due(e)) begin
                n_cmp++;
                if (observe(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc%0d: got %0h expected %0h", e.name, cyc, observe(e.sel), e.exp);
                end
            end
        end
    endtask

    // wake_cycles below the floor (1, then 0) must still take MIN_WAKE_CYCLES;
    // a mid-wakeup change to wake_cycles must not affect the latched target.
    task automatic test_min_floor();
        sb_t e;
        int  base = cyc + 1;
        for (int j = 0; j < 4; j++) expect_all(base + j, 4'b0001, 4'b0000, 1'b1, 4'(j), "floor1_wake");
        expect_all(base + 4, 4'b0001, 4'b0001, 1'b0, 4'd0, "floor1_ready");
        expect_one(base + 5, SEL_PWR, 32'h0, "floor1_release");
        for (int j = 0; j < 4; j++) expect_all(base + 6 + j, 4'b0001, 4'b0000, 1'b1, 4'(j), "floor0_wake");
        expect_all(base + 10, 4'b0001, 4'b0001, 1'b0, 4'd0, "floor0_ready");
        expect_one(base + 11, SEL_PWR, 32'h0, "floor0_release");
        for (int k = 0; k < 12; k++) begin
            case (k)
                0:  begin bus.wake_req = 4'b0001; bus.wake_cycles = 4'd1; end
                5:  bus.wake_req = 4'b0000;
                6:  begin bus.wake_req = 4'b0001; bus.wake_cycles = 4'd0; end
                7:  bus.wake_cycles = 4'd15;
                11: bus.wake_req = 4'b0000;
                default: ;
            endcase
            advance();
            while (pop_due(e)) begin
                n_cmp++;
                if (observe(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc%0d: got %0h expected %0h", e.name, cyc, observe(e.sel), e.exp);
                end
            end
        end
    endtask

    // Two simultaneous requests are serialised with one idle edge between them.
    task automatic test_back_to_back();
        sb_t e;
        int  base;
        do_reset();
        base = cyc + 1;
        for (int j = 0; j < 4; j++) expect_all(base + j, 4'b0001, 4'b0000, 1'b1, 4'(j), "b2b_bank0");
        expect_all(base + 4, 4'b0001, 4'b0001, 1'b0, 4'd0, "b2b_gap");
        for (int j = 0; j < 4; j++) expect_all(base + 5 + j, 4'b0101, 4'b0001, 1'b1, 4'(j), "b2b_bank2");
        expect_all(base + 9, 4'b0101, 4'b0101, 1'b0, 4'd0, "b2b_ready");
        expect_all(base + 10, 4'b0000, 4'b0000, 1'b0, 4'd0, "b2b_release");
        for (int k = 0; k < 11; k++) begin
            case (k)
                0:  begin bus.wake_req = 4'b0101; bus.wake_cycles = 4'd4; end
                10: bus.wake_req = 4'b0000;
                default: ;
            endcase
            advance();
            while (pop_due(e)) begin
                n_cmp++;
                if (observe(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc%0d: got %0h expected %0h", e.name, cyc, observe(e.sel), e.exp);
                end
            end
        end
    endtask

    // After bank0 was last granted, bank1 wins over a re-requesting bank0.
    task automatic test_round_robin();
        sb_t e;
        int  base;
        do_reset();
        base = cyc + 1;
        expect_all(base + 4, 4'b0001, 4'b0001, 1'b0, 4'd0, "rr_bank0_ready");
        expect_all(base + 5, 4'b0000, 4'b0000, 1'b0, 4'd0, "rr_bank0_off");
        for (int j = 0; j < 4; j++) expect_all(base + 6 + j, 4'b0010, 4'b0000, 1'b1, 4'(j), "rr_bank1_first");
        expect_all(base + 10, 4'b0010, 4'b0010, 1'b0, 4'd0, "rr_bank1_ready");
        for (int j = 0; j < 4; j++) expect_all(base + 11 + j, 4'b0011, 4'b0010, 1'b1, 4'(j), "rr_bank0_second");
        expect_all(base + 15, 4'b0011, 4'b0011, 1'b0, 4'd0, "rr_both_ready");
        expect_all(base + 16, 4'b0000, 4'b0000, 1'b0, 4'd0, "rr_release");
        for (int k = 0; k < 17; k++) begin
            case (k)
                0:  begin bus.wake_req = 4'b0001; bus.wake_cycles = 4'd4; end
                5:  bus.wake_req = 4'b0000;
                6:  bus.wake_req = 4'b0011;
                16: bus.wake_req = 4'b0000;
                default: ;
            endcase
            advance();
            while (pop_due(e)) begin
                n_cmp++;
                if (observe(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc%0d: got %0h expected %0h", e.name, cyc, observe(e.sel), e.exp);
                end
            end
        end
    endtask

    // Bank0 aborts at counter=2; queued bank3 is granted one edge later.
    task automatic test_abort();
        sb_t  e;
        int   base;
        logic saw_rdy0 = 1'b0;
        do_reset();
        base = cyc + 1;
        for (int j = 0; j < 3; j++) expect_all(base + j, 4'b0001, 4'b0000, 1'b1, 4'(j), "abort_wake");
        expect_all(base + 3, 4'b0000, 4'b0000, 1'b0, 4'd0, "abort_off");
        for (int j = 0; j < 5; j++) expect_all(base + 4 + j, 4'b1000, 4'b0000, 1'b1, 4'(j), "abort_bank3");
        expect_all(base + 9, 4'b1000, 4'b1000, 1'b0, 4'd0, "abort_bank3_ready");
        expect_all(base + 10, 4'b0000, 4'b0000, 1'b0, 4'd0, "abort_release");
        for (int k = 0; k < 11; k++) begin
            case (k)
                0:  begin bus.wake_req = 4'b1001; bus.wake_cycles = 4'd5; end
                3:  bus.wake_req = 4'b1000;
                10: bus.wake_req = 4'b0000;
                default: ;
            endcase
            advance();
            saw_rdy0 = saw_rdy0 | bus.bank_ready[0];
            while (pop_due(e)) begin
                n_cmp++;
                if (observe(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc%0d: got %0h expected %0h", e.name, cyc, observe(e.sel), e.exp);
                end
            end
        end
        n_cmp++;
        if (saw_rdy0 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_never_ready: bank_ready[0] seen %0b expected 0", saw_rdy0);
        end
    endtask

    // Reset while bank2 wakes and banks 0/1 are ready; priority restarts at bank0.
    task automatic test_reset_mid();
        sb_t e;
        int  base;
        do_reset();
        base = cyc + 1;
        expect_all(base + 4, 4'b0001, 4'b0001, 1'b0, 4'd0, "rmid_bank0_ready");
        expect_all(base + 9, 4'b0011, 4'b0011, 1'b0, 4'd0, "rmid_bank1_ready");
        expect_all(base + 11, 4'b0111, 4'b0011, 1'b1, 4'd1, "rmid_bank2_wake");
        expect_all(base + 12, 4'b0000, 4'b0000, 1'b0, 4'd0, "rmid_reset");
        expect_all(base + 13, 4'b0100, 4'b0000, 1'b1, 4'd0, "rmid_priority");
        expect_all(base + 14, 4'b0000, 4'b0000, 1'b0, 4'd0, "rmid_release");
        for (int k = 0; k < 15; k++) begin
            case (k)
                0:  begin bus.wake_req = 4'b1111; bus.wake_cycles = 4'd4; end
                12: reset = 1'b1;
                13: begin reset = 1'b0; bus.wake_req = 4'b1100; end
                14: bus.wake_req = 4'b0000;
                default: ;
            endcase
            advance();
            while (pop_due(e)) begin
                n_cmp++;
                if (observe(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @cyc%0d: got %0h expected %0h", e.name, cyc, observe(e.sel), e.exp);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wake_req    = '0;
        bus.wake_cycles = '0;
        test_reset();
        test_basic();
        test_min_floor();
        test_back_to_back();
        test_round_robin();
        test_abort();
        test_reset_mid();
        while (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: expected at cyc%0d but never compared", sb[0].name, sb[0].cyc);
            sb.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_controller_wakeup_sequencer.md
# sram_controller_wakeup_sequencer

Multi-bank successor to the single-channel wakeup timer. It sequences power-up for `NUM_BANKS` independently gated SRAM banks. Only one bank may be in its wakeup window at a time, which limits inrush current. Each bank's wakeup length is programmable, and a minimum-count safety floor applies. The FSM and the HREADY gating logic consume `bank_ready` per bank; the bank power switches consume `power_en`.

## Interface
- `NUM_BANKS`, 4: number of independently powered banks (1..16).
- `CNT_W`, 4: width of the wake-cycle count and the counter.
- `MIN_WAKE_CYCLES`, 4: safety floor. Programmed values below this are raised to it (1..2^CNT_W-1).

- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `wake_req`  in  NUM_BANKS  per-bank level request. High means keep the bank powered; low means power it down.
- `wake_cycles`  in  CNT_W  programmed wakeup length. Sampled only when a bank is granted.
- `power_en`  out  NUM_BANKS  bank power-switch enable. High in WAKING and READY.
- `bank_ready`  out  NUM_BANKS  bank usable. High only in READY.
- `busy`  out  1  some bank is in WAKING.
- `wake_count`  out  CNT_W  debug: shared counter value. Zero when not busy.

## Operation
- Each bank has a 2-bit state: OFF, QUEUED, WAKING, READY. There is one shared counter, one latched target register and one round-robin pointer `last_grant`.
- Target = max(`wake_cycles`, `MIN_WAKE_CYCLES`), latched on the grant edge. Later changes to `wake_cycles` do not affect a wakeup already in progress.
- OFF → QUEUED when `wake_req` is high. If the bank wins the grant on the same edge, it goes OFF → WAKING directly.
- Grant: evaluated on an edge where no bank is WAKING in the pre-edge state. Candidates are banks in QUEUED, or in OFF with `wake_req` high. The search starts at `last_grant+1` and wraps modulo `NUM_BANKS`. On grant, the winner enters WAKING, the counter is cleared to 0, and `last_grant` is set to the winner.
- WAKING: if counter == target-1, the bank goes to READY and the counter returns to 0. Otherwise the counter increments. The counter never wraps because target ≤ 2^CNT_W-1.
- READY persists while `wake_req` is high.
- `wake_req` low in any state → OFF on the next edge. In WAKING this aborts the wakeup and clears the counter. `bank_ready` is never asserted for an aborted wakeup.
- A bank that completes or aborts frees the slot. The next grant happens on the following edge, which always gives at least one idle cycle between bank wakeups.
- At most one bank is ever WAKING. A bank reaches READY only after exactly target consecutive WAKING cycles.

## Timing
- Reset: every bank goes to OFF, counter and target are 0, and `last_grant` = NUM_BANKS-1, so bank 0 has first priority. All outputs are 0 in the cycle after the reset edge. Reset overrides every other event, including in mid-wakeup.
- Uncontended request, first sampled high at edge E0 → WAKING from E0 (`power_en` high after E0). `bank_ready` rises after edge E(target), giving target cycles of power before ready.
- Release latency: one edge from `wake_req` low to `power_en`/`bank_ready` low.
- `wake_count` shows 0..target-1 during WAKING, one value per cycle.
- If a bank drops its request on the same edge another bank completes, both transitions apply independently.
- Request re-asserted on the cycle after a release: the bank re-enters arbitration from OFF and does a full wakeup again.

## Test plan
- Reset, then `wake_req`=0001 and `wake_cycles`=6 at E0 → `power_en`[0] high after E0; `wake_count` 0..5; `bank_ready`[0] high after E6; `busy` low after E6.
- `wake_cycles`=1 with `MIN_WAKE_CYCLES`=4 → `bank_ready` after E4, not E1. Setting `wake_cycles`=0 gives the same result.
- `wake_req`=0101 at E0, `wake_cycles`=4 → bank0 WAKING E0–E3, READY after E4. Bank2 granted at E5, READY after E9. Bank2 `power_en` is low before E5.
- Round-robin fairness: after bank0 completes, `wake_req`=0011 with bank0 re-requested → bank1 is granted before bank0.
- Abort: bank0 WAKING, `wake_req`[0] dropped at counter=2 → bank0 OFF next edge, `bank_ready`[0] never high, queued bank3 granted one edge later.
- `reset` asserted mid-wakeup with two banks READY → every output is 0 after that edge, and the next request starts from bank 0 priority.
